// File: rtl/i2s_pkg.sv
// Shared types and default parameters for the I2S transmitter.
package i2s_pkg;

   localparam int unsigned DEF_WD         = 24;
   localparam int unsigned DEF_SLOT_BITS  = 32;
   localparam int unsigned DEF_BCLK_DIV   = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   typedef struct packed {
      logic signed [DEF_WD-1:0] l;
      logic signed [DEF_WD-1:0] r;
   } stereo_t;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } lr_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_e;

endpackage

// File: rtl/i2s_tx_sync_fifo.sv
// Synchronous frame FIFO with registered full/empty/level flags.
module i2s_tx_sync_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [LW-1:0]    w_level_nxt;

   assign w_do_push = push & ~r_full;
   assign w_do_pop  = pop & ~r_empty;

   // Next occupancy; a pop from empty or a push into full is ignored.
   always_comb begin
      w_level_nxt = r_level;
      if (w_do_push && !w_do_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   // Pointers and flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LW'(DEPTH));
         r_empty <= (w_level_nxt == LW'(0));
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign full    = r_full;
   assign empty   = r_empty;
   assign level   = r_level;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: frame FIFO, BCLK/LRCLK generation and MSB-first serialiser.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int unsigned WD         = DEF_WD,
   parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
   parameter int unsigned BCLK_DIV   = DEF_BCLK_DIV,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WD-1:0]                 in_data_l,
   input  logic [WD-1:0]                 in_data_r,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned DIV_W = $clog2(BCLK_DIV);
   localparam int unsigned BIT_W = $clog2(SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(SLOT_BITS - 1);

   run_state_e       r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_bclk;
   logic             r_lrclk;
   logic             r_sdata;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [WD-1:0]    r_shreg;
   logic [WD-1:0]    r_hold_r;
   logic             r_underrun;

   run_state_e       w_state_nxt;
   logic [DIV_W-1:0] w_div_nxt;
   logic             w_bclk_nxt;
   logic             w_lrclk_nxt;
   logic             w_sdata_nxt;
   logic [BIT_W-1:0] w_bit_nxt;
   logic [WD-1:0]    w_shreg_nxt;
   logic [WD-1:0]    w_hold_nxt;
   logic             w_underrun_nxt;
   logic             w_wrap;
   logic             w_fall;
   logic             w_start;
   logic [BIT_W-1:0] w_k_nxt;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [2*WD-1:0]  w_rd_data;

   i2s_tx_sync_fifo #(
      .WIDTH (2*WD),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (in_valid),
      .pop     (w_pop),
      .wr_data ({in_data_l, in_data_r}),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level)
   );

   // Run FSM, divider, slot counter and serialiser next-state logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_div_nxt      = r_div_cnt;
      w_bclk_nxt     = r_bclk;
      w_lrclk_nxt    = r_lrclk;
      w_sdata_nxt    = r_sdata;
      w_bit_nxt      = r_bit_cnt;
      w_shreg_nxt    = r_shreg;
      w_hold_nxt     = r_hold_r;
      w_underrun_nxt = r_underrun;
      w_wrap         = (r_div_cnt == DIV_MAX);
      w_fall         = 1'b0;
      w_start        = 1'b0;
      w_pop          = 1'b0;
      w_k_nxt        = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + BIT_W'(1);

      case (r_state)
         IDLE: begin
            w_div_nxt   = '0;
            w_bclk_nxt  = 1'b0;
            w_lrclk_nxt = RIGHT;
            w_sdata_nxt = 1'b0;
            w_bit_nxt   = BIT_MAX;
            if (en) begin
               w_start     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_wrap) begin
               w_div_nxt  = '0;
               w_bclk_nxt = ~r_bclk;
               w_fall     = r_bclk;
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end

            if (w_fall && (r_bit_cnt == BIT_MAX) && (r_lrclk == RIGHT)) begin
               // Frame boundary: continue or park with outputs quiet.
               if (en) begin
                  w_start = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_sdata_nxt = 1'b0;
               end
            end else if (w_fall) begin
               w_bit_nxt = w_k_nxt;
               if (r_bit_cnt == BIT_MAX) begin
                  // Left-to-right slot change: right word enters the shifter.
                  w_lrclk_nxt = ~r_lrclk;
                  w_shreg_nxt = r_hold_r;
                  w_sdata_nxt = 1'b0;
               end else if ((w_k_nxt >= BIT_W'(1)) && (w_k_nxt <= BIT_W'(WD))) begin
                  w_sdata_nxt = r_shreg[WD-1];
                  w_shreg_nxt = {r_shreg[WD-2:0], 1'b0};
               end else begin
                  w_sdata_nxt = 1'b0;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Frame start: pop a stereo frame, or send silence on underrun.
      if (w_start) begin
         w_pop       = 1'b1;
         w_bit_nxt   = '0;
         w_lrclk_nxt = LEFT;
         w_sdata_nxt = 1'b0;
         w_div_nxt   = '0;
         w_bclk_nxt  = 1'b0;
         if (w_empty) begin
            w_shreg_nxt    = '0;
            w_hold_nxt     = '0;
            w_underrun_nxt = 1'b1;
         end else begin
            w_shreg_nxt = w_rd_data[2*WD-1:WD];
            w_hold_nxt  = w_rd_data[WD-1:0];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_div_cnt  <= '0;
         r_bclk     <= 1'b0;
         r_lrclk    <= RIGHT;
         r_sdata    <= 1'b0;
         r_bit_cnt  <= BIT_MAX;
         r_shreg    <= '0;
         r_hold_r   <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div_cnt  <= w_div_nxt;
         r_bclk     <= w_bclk_nxt;
         r_lrclk    <= w_lrclk_nxt;
         r_sdata    <= w_sdata_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shreg    <= w_shreg_nxt;
         r_hold_r   <= w_hold_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign in_ready  = ~w_full;
   assign i2s_bclk  = r_bclk;
   assign i2s_lrclk = r_lrclk;
   assign i2s_sdata = r_sdata;
   assign underrun  = r_underrun;

endmodule
